tilelink_ul_mem_slave: RTL and testbench
========================================

// Module: tilelink_ul_mem_slave
// PURPOSE
//  Parametrised TileLink-UL memory slave: SRAM-backed endpoint serving Get, PutFullData and PutPartialData.
//  Successor to the fixed single-response slave, adding:
//   - configurable depth, base address and data width;
//   - an in-order response queue, so A keeps accepting while D is back-pressured;
//   - checking of size, alignment, mask and opcode, with errors reported on D.
//  Sits behind the crossbar as a leaf scratchpad.
// PARAMETERS
//  TL_ADDR_WIDTH    64  A/D address width
//  TL_DATA_WIDTH    64  data width; power of 2, >=8; TL_STRB_WIDTH = TL_DATA_WIDTH/8
//  TL_SOURCE_WIDTH   3  source ID width
//  TL_SINK_WIDTH     3  sink ID width
//  TL_SIZE_WIDTH     8  size field width (log2 bytes)
//  MEM_DEPTH       256  words of storage; power of 2
//  BASE_ADDR         0  byte address of word 0
//  RSP_DEPTH         4  response queue entries; power of 2, >=2
//  SINK_ID           0  constant driven on d_sink
// PORTS
//  clk        in   1                single clock, all logic on rising edge
//  rst        in   1                synchronous, active-high reset
//  a_valid    in   1                A request valid
//  a_ready    out  1                A request accepted when a_valid&&a_ready
//  a_opcode   in   3                0 PutFull, 1 PutPartial, 4 Get
//  a_param    in   3                ignored
//  a_address  in   TL_ADDR_WIDTH    byte address
//  a_size     in   TL_SIZE_WIDTH    log2 transfer bytes
//  a_mask     in   TL_STRB_WIDTH    byte lane enables
//  a_data     in   TL_DATA_WIDTH    write data
//  a_source   in   TL_SOURCE_WIDTH  requester ID
//  d_valid    out  1                response valid
//  d_ready    in   1                response consumed when d_valid&&d_ready
//  d_opcode   out  3                0 AccessAck (Put), 1 AccessAckData (Get)
//  d_param    out  3                always 0
//  d_size     out  TL_SIZE_WIDTH    echo of a_size
//  d_sink     out  TL_SINK_WIDTH    always SINK_ID
//  d_source   out  TL_SOURCE_WIDTH  echo of a_source
//  d_data     out  TL_DATA_WIDTH    Get read word; 0 for Put or error
//  d_error    out  1                1 = request denied, memory untouched
// BEHAVIOUR
//  - Reset: all state is cleared (the queue holds nothing); d_valid=0, d_error=0, d_data=0, d_opcode=0,
//    d_size=0, d_source=0. a_ready=0 while rst=1 and =1 the cycle after. Memory array is not reset.
//  - Reset mid-operation: queued responses are dropped. Puts accepted before the reset edge stay in memory.
//  - a_ready = (queue count < RSP_DEPTH). There is no combinational path from d_ready to a_ready.
//  - Acceptance (a_valid && a_ready):
//    - Validity checks run in the same cycle.
//    - A valid Put writes the masked lanes at the end of that cycle.
//    - A valid Get reads the word, including any write committed on an earlier edge.
//    - One queue entry {opcode,size,source,error,data} is pushed at that edge.
//  - Latency: a response is on D no earlier than the cycle after its acceptance.
//    - With an empty queue and d_ready=1, throughput is 1 request per clock.
//    - Responses leave strictly in acceptance order.
//  - D hold: while d_valid && !d_ready, all d_* outputs stay stable.
//  - Word index = (a_address - BASE_ADDR) >> log2(TL_STRB_WIDTH). The lane offset is the low address bits.
//  - Error conditions (any one sets d_error=1; no write is made; d_data=0):
//    - opcode not in {0,1,4};
//    - a_size > log2(TL_STRB_WIDTH);
//    - address not aligned to 2^a_size;
//    - PutFull with a_mask != the lane mask implied by size and offset;
//    - PutPartial with a_mask set outside that lane mask;
//    - address out of range (see CONFIGURATION).
//  - Get returns the full word regardless of mask. The master extracts its lanes.
//  - Queue boundaries:
//    - Full with a pop this cycle: no push this cycle; a_ready rises the next cycle.
//    - Push and pop in the same cycle: count is unchanged.
//    - Pointers wrap modulo RSP_DEPTH.
// CONFIGURATION
//  TLUL_MEM_ADDR_CHECK_EN
//   - Defined: an address below BASE_ADDR or >= BASE_ADDR + MEM_DEPTH*TL_STRB_WIDTH is an error
//     response (d_error=1, memory untouched).
//   - Undefined: no range check. The word index wraps modulo MEM_DEPTH and the access completes normally.
// TESTING
//  1. PutFull 0x10 = 0xDEADBEEFCAFEBABE, size 3, mask 0xFF, source 1; then Get 0x10
//     -> AccessAck err 0; then AccessAckData, d_data = 0xDEADBEEFCAFEBABE, d_source = 1.
//  2. PutFull 0x20 = 0xFFFFFFFFFFFFFFFF; PutPartial 0x20 = 0x123456789ABCDEF0, mask 0x0F; Get 0x20
//     -> d_data = 0xFFFFFFFF9ABCDEF0.
//  3. d_ready=0; issue 5 back-to-back Gets with sources 0..4 (RSP_DEPTH=4)
//     -> a_ready=0 after the 4th accept. Release d_ready: 5 responses in source order 0..4, none lost.
//  4. Get size 3 at 0x14; then Put size 4; then opcode 2
//     -> three responses, each d_error=1 and d_data=0; the following Get 0x10 is unchanged.
//  5. Get at 0x800 with MEM_DEPTH=256:
//     - TLUL_MEM_ADDR_CHECK_EN defined -> d_error=1;
//     - undefined -> d_error=0 and d_data = word 0.
//  6. Queue 3 responses; assert rst for 1 cycle -> d_valid=0 the next cycle. Get 0x10 returns the pre-reset write.

Source files
------------

// File: rtl/tilelink_ul_mem_slave.sv
// TileLink-UL SRAM slave serving Get / PutFullData / PutPartialData with an in-order response queue.
// Latency: response on D one cycle after acceptance at the earliest; 1 request/clock when D is not stalled.
// Backpressure: A accepts while the response queue has room; D outputs hold while d_valid && !d_ready.
//
// Ports: clk/rst (synchronous, active-high); A channel a_valid/a_ready/a_opcode/a_param/a_address/a_size/
//        a_mask/a_data/a_source; D channel d_valid/d_ready/d_opcode/d_param/d_size/d_sink/d_source/d_data/d_error.
// Optional feature macro: TLUL_MEM_ADDR_CHECK_EN -- when defined, addresses outside
//        [BASE_ADDR, BASE_ADDR + MEM_DEPTH*bytes-per-word) are denied; otherwise the word index wraps.
module tilelink_ul_mem_slave #(
  parameter int                        TL_ADDR_WIDTH   = 64,
  parameter int                        TL_DATA_WIDTH   = 64,
  parameter int                        TL_SOURCE_WIDTH = 3,
  parameter int                        TL_SINK_WIDTH   = 3,
  parameter int                        TL_SIZE_WIDTH   = 8,
  parameter int                        MEM_DEPTH       = 256,
  parameter logic [TL_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter int                        RSP_DEPTH       = 4,
  parameter int                        SINK_ID         = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [2:0]                   a_opcode,
  input  logic [2:0]                   a_param,
  input  logic [TL_ADDR_WIDTH-1:0]     a_address,
  input  logic [TL_SIZE_WIDTH-1:0]     a_size,
  input  logic [TL_DATA_WIDTH/8-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]     a_data,
  input  logic [TL_SOURCE_WIDTH-1:0]   a_source,
  output logic                         d_valid,
  input  logic                         d_ready,
  output logic [2:0]                   d_opcode,
  output logic [2:0]                   d_param,
  output logic [TL_SIZE_WIDTH-1:0]     d_size,
  output logic [TL_SINK_WIDTH-1:0]     d_sink,
  output logic [TL_SOURCE_WIDTH-1:0]   d_source,
  output logic [TL_DATA_WIDTH-1:0]     d_data,
  output logic                         d_error
);

  localparam int LANES      = TL_DATA_WIDTH / 8;
  localparam int LOG2_LANES = $clog2(LANES);
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam int PTR_W      = $clog2(RSP_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic [2:0]                 opcode;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic                       error;
    logic [TL_DATA_WIDTH-1:0]   data;
  } rsp_t;

  logic [TL_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  rsp_t                     rsp_q [RSP_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;

  logic                     accept, pop;
  logic [TL_ADDR_WIDTH-1:0] rel_addr;
  logic [IDX_W-1:0]         idx;
  logic [LANES-1:0]         lane_mask;
  logic                     is_get, is_put, size_ok, align_ok, mask_ok, range_ok, req_err;
  int                       nbytes, offset;
  rsp_t                     rsp_new, rsp_head;
  logic                     unused;

  // a_ready depends only on registered count (and rst), never on d_ready.
  assign a_ready  = !rst && (count < CNT_W'(RSP_DEPTH));
  assign accept   = a_valid && a_ready;
  assign d_valid  = (count != '0);
  assign pop      = d_valid && d_ready;

  // Word index wraps modulo MEM_DEPTH by simply dropping the upper bits.
  assign rel_addr = a_address - BASE_ADDR;
  assign idx      = rel_addr[LOG2_LANES +: IDX_W];
  assign unused   = ^{a_param, rel_addr};

  always_comb begin
    is_get   = (a_opcode == 3'd4);
    is_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    size_ok  = (a_size <= TL_SIZE_WIDTH'(LOG2_LANES));
    nbytes   = 1;
    if (size_ok) nbytes = 1 << a_size;
    offset   = int'(a_address & TL_ADDR_WIDTH'(LANES - 1));
    align_ok = ((a_address & TL_ADDR_WIDTH'(nbytes - 1)) == '0);
    // Lanes covered by a naturally aligned transfer of 2^a_size bytes.
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = (i >= offset) && (i < offset + nbytes);
    end
    if (a_opcode == 3'd0)      mask_ok = (a_mask == lane_mask);
    else if (a_opcode == 3'd1) mask_ok = ((a_mask & ~lane_mask) == '0);
    else                       mask_ok = 1'b1;
`ifdef TLUL_MEM_ADDR_CHECK_EN
    range_ok = (a_address >= BASE_ADDR) && (rel_addr < TL_ADDR_WIDTH'(MEM_DEPTH * LANES));
`else
    range_ok = 1'b1;
`endif
    req_err = !((is_get || is_put) && size_ok && align_ok && mask_ok && range_ok);

    rsp_new.opcode = is_get ? 3'd1 : 3'd0;
    rsp_new.size   = a_size;
    rsp_new.source = a_source;
    rsp_new.error  = req_err;
    rsp_new.data   = (is_get && !req_err) ? mem[idx] : '0;

    rsp_head = rsp_q[rd_ptr];
  end

  // Storage array is never reset; Puts committed before a reset survive it.
  always_ff @(posedge clk) begin
    if (accept && is_put && !req_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rsp_q[wr_ptr] <= rsp_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry is gated so an empty queue presents all-zero D fields.
  assign d_opcode = d_valid ? rsp_head.opcode : '0;
  assign d_size   = d_valid ? rsp_head.size   : '0;
  assign d_source = d_valid ? rsp_head.source : '0;
  assign d_error  = d_valid ? rsp_head.error  : 1'b0;
  assign d_data   = d_valid ? rsp_head.data   : '0;
  assign d_param  = '0;
  assign d_sink   = TL_SINK_WIDTH'(SINK_ID);

endmodule

// File: tb/tb_tilelink_ul_mem_slave.sv
// Testbench for tilelink_ul_mem_slave: directed scenarios plus randomized traffic
// checked against a byte-level memory model and an expected-response queue.
// Every D handshake, a_ready/d_valid each cycle, and D stability under stall are compared.
module tb_tilelink_ul_mem_slave;

  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [63:0] a_address;
  logic [7:0]  a_size;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic [2:0]  a_source;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param;
  logic [7:0]  d_size;
  logic [2:0]  d_sink, d_source;
  logic [63:0] d_data;
  logic        d_error;

  always #5 clk = ~clk;

  tilelink_ul_mem_slave #(
    .TL_ADDR_WIDTH(64), .TL_DATA_WIDTH(64), .TL_SOURCE_WIDTH(3), .TL_SINK_WIDTH(3),
    .TL_SIZE_WIDTH(8), .MEM_DEPTH(256), .BASE_ADDR(64'h0), .RSP_DEPTH(RSP_DEPTH), .SINK_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_sink(d_sink), .d_source(d_source), .d_data(d_data), .d_error(d_error)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  size;
    logic [2:0]  src;
    logic        err;
    logic [63:0] data;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  logic [2:0]  src_log[$];
  logic [63:0] mem_m [256];
  logic [63:0] last_data;
  logic        last_err;
  logic [2:0]  last_src;
  logic        stall_prev = 1'b0;
  logic [85:0] held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: decide legality from the protocol rules, then apply to a byte-addressed word array.
  task automatic model_accept();
    exp_t e;
    int   nb, off, lm, widx;
    logic bad;
    off  = int'(a_address[2:0]);
    bad  = !(a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4);
    if (a_size > 8'd3) bad = 1'b1;
    else begin
      nb = 1 << a_size;
      lm = ((1 << nb) - 1) << off;
      if ((off % nb) != 0) bad = 1'b1;
      if (a_opcode == 3'd0 && int'(a_mask) != lm) bad = 1'b1;
      if (a_opcode == 3'd1 && (int'(a_mask) & ~lm) != 0) bad = 1'b1;
    end
`ifdef TLUL_MEM_ADDR_CHECK_EN
    if (a_address >= 64'h800) bad = 1'b1;
`endif
    widx   = int'(a_address[10:3]);
    e.op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
    e.size = a_size;
    e.src  = a_source;
    e.err  = bad;
    e.data = '0;
    if (!bad && a_opcode == 3'd4) e.data = mem_m[widx];
    if (!bad && a_opcode != 3'd4) begin
      for (int b = 0; b < 8; b++) if (a_mask[b]) mem_m[widx][8*b +: 8] = a_data[8*b +: 8];
    end
    exp_q.push_back(e);
  endtask

  // Cycle monitor: sampled on the falling edge, half a cycle away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    chk("a_ready", 128'(a_ready), 128'(!rst && exp_q.size() < RSP_DEPTH));
    chk("d_valid", 128'(d_valid), 128'(exp_q.size() != 0));
    if (stall_prev)
      chk("d_hold", 128'({d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error}), 128'(held));
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (d_valid && d_ready) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL d_spurious: observed response src %0d expected none", d_source);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("d_fields", 128'({d_opcode, d_size, d_source, d_error, d_data}),
              128'({e.op, e.size, e.src, e.err, e.data}));
          chk("d_param_sink", 128'({d_param, d_sink}), 128'(0));
        end
        last_data = d_data;
        last_err  = d_error;
        last_src  = d_source;
        src_log.push_back(d_source);
      end
      if (a_valid && a_ready) model_accept();
      stall_prev = d_valid && !d_ready;
      held = {d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error};
    end
  end

  task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] sz,
                      input logic [7:0] msk, input logic [63:0] dat, input logic [2:0] src,
                      input bit rand_dr);
    int   guard = 0;
    logic ok;
    a_valid = 1'b1; a_opcode = op; a_param = 3'($urandom); a_address = addr;
    a_size = sz; a_mask = msk; a_data = dat; a_source = src;
    do begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      if (rand_dr) d_ready = 1'($urandom_range(0, 1));
      guard++;
    end while (!ok && guard < 200);
    a_valid = 1'b0;
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL send_timeout: observed no accept in %0d cycles expected accept", guard);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [63:0] w0, d, addr;
    logic [7:0]  sz, msk;
    logic [2:0]  op;
    int          r, lm;

    rst = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_address = '0;
    a_size = '0; a_mask = '0; a_data = '0; a_source = '0; d_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    chk("reset_d_outputs", 128'({d_valid, d_error, d_data, d_opcode, d_size, d_source}), 128'(0));
    @(posedge clk); #1;

    // Preload every word so later Gets have defined data.
    w0 = '0;
    for (int w = 0; w < 256; w++) begin
      d = {$urandom, $urandom};
      if (w == 0) w0 = d;
      send(3'd0, 64'(w * 8), 8'd3, 8'hFF, d, 3'(w), 1'b0);
    end
    drain();

    // Full-word write then read back.
    send(3'd0, 64'h10, 8'd3, 8'hFF, 64'hDEADBEEFCAFEBABE, 3'd1, 1'b0);
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'd1, 1'b0);
    drain();
    chk("t1_data", 128'(last_data), 128'(64'hDEADBEEFCAFEBABE));
    chk("t1_source", 128'(last_src), 128'(1));

    // Partial write merges with existing word.
    send(3'd0, 64'h20, 8'd3, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 3'd2, 1'b0);
    send(3'd1, 64'h20, 8'd3, 8'h0F, 64'h123456789ABCDEF0, 3'd2, 1'b0);
    send(3'd4, 64'h20, 8'd3, 8'hFF, 64'h0, 3'd2, 1'b0);
    drain();
    chk("t2_data", 128'(last_data), 128'(64'hFFFFFFFF9ABCDEF0));

    // Fill the queue under D stall, then release and check ordering.
    src_log.delete();
    d_ready = 1'b0;
    for (int s = 0; s < 4; s++) send(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'(s), 1'b0);
    @(negedge clk);
    chk("t3_full_a_ready", 128'(a_ready), 128'(0));
    @(posedge clk); #1;
    d_ready = 1'b1;
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'd4, 1'b0);
    drain();
    chk("t3_count", 128'(src_log.size()), 128'(5));
    for (int i = 0; i < 5; i++) chk("t3_order", 128'(src_log[i]), 128'(i));

    // Error cases: misaligned, oversize, bad opcode.
    send(3'd4, 64'h14, 8'd3, 8'hFF, 64'h0, 3'd3, 1'b0);
    drain();
    chk("t4_misalign", 128'({last_err, last_data}), 128'({1'b1, 64'h0}));
    send(3'd0, 64'h10, 8'd4, 8'hFF, 64'h1111111111111111, 3'd3, 1'b0);
    drain();
    chk("t4_oversize", 128'({last_err, last_data}), 128'({1'b1, 64'h0}));
    send(3'd2, 64'h10, 8'd3, 8'hFF, 64'h2222222222222222, 3'd3, 1'b0);
    drain();
    chk("t4_bad_opcode", 128'({last_err, last_data}), 128'({1'b1, 64'h0}));
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'd3, 1'b0);
    drain();
    chk("t4_unchanged", 128'({last_err, last_data}), 128'({1'b0, 64'hDEADBEEFCAFEBABE}));

    // Out-of-range address.
    send(3'd4, 64'h800, 8'd3, 8'hFF, 64'h0, 3'd4, 1'b0);
    drain();
`ifdef TLUL_MEM_ADDR_CHECK_EN
    chk("t5_range_err", 128'({last_err, last_data}), 128'({1'b1, 64'h0}));
`else
    chk("t5_wrap", 128'({last_err, last_data}), 128'({1'b0, w0}));
`endif

    // Reset with queued responses; committed Put must survive.
    d_ready = 1'b0;
    send(3'd0, 64'h10, 8'd3, 8'hFF, 64'h0011223344556677, 3'd5, 1'b0);
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'd6, 1'b0);
    send(3'd4, 64'h20, 8'd3, 8'hFF, 64'h0, 3'd7, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_d_valid_after_rst", 128'(d_valid), 128'(0));
    @(posedge clk); #1;
    d_ready = 1'b1;
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'd1, 1'b0);
    drain();
    chk("t6_data_kept", 128'(last_data), 128'(64'h0011223344556677));

    // Randomized traffic with random D back-pressure.
    for (int n = 0; n < 500; n++) begin
      r  = int'($urandom_range(0, 99));
      op = (r < 40) ? 3'd4 : (r < 70) ? 3'd0 : (r < 95) ? 3'd1 : 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(4, 9)) : 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = 64'($urandom_range(0, 4095));
      else begin
        addr = 64'($urandom_range(0, 2047));
        if (sz <= 8'd3 && $urandom_range(0, 9) != 0) addr = addr & ~64'((1 << sz) - 1);
      end
      lm = 0;
      if (sz <= 8'd3) lm = (((1 << (1 << sz)) - 1) << addr[2:0]) & 255;
      if ($urandom_range(0, 9) == 0) msk = 8'($urandom);
      else if (op == 3'd1)           msk = 8'(lm) & 8'($urandom);
      else                           msk = 8'(lm);
      send(op, addr, sz, msk, {$urandom, $urandom}, 3'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    d_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
